// File: rtl/dpwm_multicanal.sv
// Multi-channel DPWM: one shared prescaler and period counter feeding CHANNELS duty
// comparators, with double-buffered period/duty and an optional per-period soft-start ramp.
module dpwm_multicanal #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int PRESC_W  = 6,
   parameter int STEP_W   = 4,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PRESC_W-1:0]  presc,
   input  logic                per_wr,
   input  logic [WIDTH-1:0]    per_val,
   input  logic                duty_wr,
   input  logic [CH_W-1:0]     duty_ch,
   input  logic [WIDTH-1:0]    duty_val,
   input  logic                ramp_en,
   input  logic [STEP_W-1:0]   ramp_step,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                sync,
   output logic [CHANNELS-1:0] ramping
);

   // Write strobes are single-cycle and always accepted (no back-pressure); they only
   // touch the shadow registers, which are copied to the active set at a period boundary.

   logic [PRESC_W-1:0] presc_cnt;
   logic               tick;
   logic               boundary;
   logic [WIDTH-1:0]   cnt;
   logic [WIDTH-1:0]   per_sh;
   logic [WIDTH-1:0]   per_act;
   logic [WIDTH-1:0]   step_ext;
   logic [WIDTH-1:0]   duty_sh  [CHANNELS];
   logic [WIDTH-1:0]   duty_act [CHANNELS];
   logic [WIDTH-1:0]   duty_nxt [CHANNELS];

   // >= rather than == so a live shrink of presc below the running count wraps at once
   assign tick     = (presc_cnt >= presc);
   assign boundary = tick && (cnt == per_act);
   assign step_ext = (ramp_step == '0) ? WIDTH'(1) : WIDTH'(ramp_step);

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         duty_nxt[i] = duty_act[i];
         if (!ramp_en) begin
            duty_nxt[i] = duty_sh[i];
         end else if (duty_act[i] < duty_sh[i]) begin
            if ((duty_sh[i] - duty_act[i]) <= step_ext) duty_nxt[i] = duty_sh[i];
            else                                        duty_nxt[i] = duty_act[i] + step_ext;
         end else if (duty_act[i] > duty_sh[i]) begin
            if ((duty_act[i] - duty_sh[i]) <= step_ext) duty_nxt[i] = duty_sh[i];
            else                                        duty_nxt[i] = duty_act[i] - step_ext;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt <= '0;
         cnt       <= '0;
         per_act   <= '1;
         sync      <= 1'b0;
      end else begin
         presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
         if (tick) cnt <= (cnt == per_act) ? '0 : cnt + 1'b1;
         if (boundary) per_act <= per_sh;
         sync <= boundary;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_sh <= '1;
         for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
      end else begin
         if (per_wr) per_sh <= per_val;
         for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr && (int'(duty_ch) == i)) duty_sh[i] <= duty_val;
         end
      end
   end

   // Compare against the registered cnt, so pwm_out trails the counter by one clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out <= '0;
         ramping <= '0;
         for (int i = 0; i < CHANNELS; i++) duty_act[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (boundary) duty_act[i] <= duty_nxt[i];
            pwm_out[i] <= (cnt < duty_act[i]);
            ramping[i] <= (duty_act[i] != duty_sh[i]);
         end
      end
   end

endmodule

// File: tb/tb_dpwm_multicanal.sv
// Directed bench for dpwm_multicanal: period/duty timing, clamps, boundary-coincident
// writes, soft-start ramp, out-of-range channel writes and asynchronous reset.
module tb_dpwm_multicanal;

   localparam int CH = 5;

   logic          clk;
   logic          rst;
   logic [5:0]    presc;
   logic          per_wr;
   logic [7:0]    per_val;
   logic          duty_wr;
   logic [2:0]    duty_ch;
   logic [7:0]    duty_val;
   logic          ramp_en;
   logic [3:0]    ramp_step;
   logic [CH-1:0] pwm_out;
   logic          sync;
   logic [CH-1:0] ramping;

   int total = 0;
   int bad   = 0;

   int            hi [CH];
   int            sync_n;
   int            sync_pos;
   logic [CH-1:0] ramp_mid;
   bit            ok;

   dpwm_multicanal #(.CHANNELS(CH), .WIDTH(8), .PRESC_W(6), .STEP_W(4)) dut (
      .clk(clk), .rst(rst), .presc(presc), .per_wr(per_wr), .per_val(per_val),
      .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_val(duty_val),
      .ramp_en(ramp_en), .ramp_step(ramp_step),
      .pwm_out(pwm_out), .sync(sync), .ramping(ramping)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic wr_duty(input int ch, input int val);
      duty_wr  = 1'b1;
      duty_ch  = 3'(ch);
      duty_val = 8'(val);
      @(negedge clk);
      duty_wr  = 1'b0;
   endtask

   task automatic wr_per(input int val);
      per_wr  = 1'b1;
      per_val = 8'(val);
      @(negedge clk);
      per_wr  = 1'b0;
   endtask

   task automatic wait_sync(input int lim, output bit found);
      found = 1'b0;
      for (int k = 0; k < lim && !found; k++) begin
         @(negedge clk);
         if (sync) found = 1'b1;
      end
   endtask

   // Samples n consecutive negedges: per-channel high count, sync count/position, mid ramping
   task automatic measure(input int n);
      for (int c = 0; c < CH; c++) hi[c] = 0;
      sync_n = 0;
      sync_pos = 0;
      ramp_mid = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
         if (sync) begin
            sync_n++;
            sync_pos = k;
         end
         if (k == n / 2) ramp_mid = ramping;
      end
   endtask

   task automatic test_reset();
      total++;
      if (pwm_out !== '0) begin bad++; $display("FAIL reset_pwm got=%b want=0", pwm_out); end
      total++;
      if (sync !== 1'b0) begin bad++; $display("FAIL reset_sync got=%b want=0", sync); end
      total++;
      if (ramping !== '0) begin bad++; $display("FAIL reset_ramping got=%b want=0", ramping); end
   endtask

   task automatic test_basic();
      int first;
      first = 0;
      rst = 1'b0;
      per_wr = 1'b1; per_val = 8'd9;
      duty_wr = 1'b1; duty_ch = 3'd0; duty_val = 8'd3;
      for (int k = 1; k <= 300 && first == 0; k++) begin
         @(negedge clk);
         per_wr = 1'b0;
         duty_wr = 1'b0;
         if (sync) first = k;
      end
      total++;
      if (first != 256) begin bad++; $display("FAIL first_boundary got=%0d want=256", first); end
      for (int p = 0; p < 2; p++) begin
         measure(10);
         total++;
         if (hi[0] != 3) begin bad++; $display("FAIL basic_duty got=%0d want=3", hi[0]); end
         total++;
         if (sync_n != 1 || sync_pos != 10) begin
            bad++; $display("FAIL basic_sync got=%0d@%0d want=1@10", sync_n, sync_pos);
         end
      end
   endtask

   task automatic test_clamps();
      presc = 6'd3;
      wr_per(4);
      wr_duty(1, 5);
      wr_duty(2, 0);
      wait_sync(100, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL clamp_wait got=timeout want=sync"); end
      for (int p = 0; p < 2; p++) begin
         measure(20);
         total++;
         if (hi[1] != 20) begin bad++; $display("FAIL clamp_full got=%0d want=20", hi[1]); end
         total++;
         if (hi[2] != 0) begin bad++; $display("FAIL clamp_zero got=%0d want=0", hi[2]); end
         total++;
         if (hi[0] != 12) begin bad++; $display("FAIL clamp_ch0 got=%0d want=12", hi[0]); end
         total++;
         if (sync_n != 1 || sync_pos != 20) begin
            bad++; $display("FAIL clamp_sync got=%0d@%0d want=1@20", sync_n, sync_pos);
         end
      end
   endtask

   task automatic test_boundary_write();
      presc = 6'd0;
      wr_per(9);
      wr_duty(0, 2);
      wait_sync(100, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bw_wait got=timeout want=sync"); end
      repeat (9) @(negedge clk);
      wr_duty(0, 7);
      total++;
      if (sync !== 1'b1) begin bad++; $display("FAIL bw_coincide got=%b want=1", sync); end
      measure(10);
      total++;
      if (hi[0] != 2) begin bad++; $display("FAIL bw_old got=%0d want=2", hi[0]); end
      measure(10);
      total++;
      if (hi[0] != 7) begin bad++; $display("FAIL bw_new got=%0d want=7", hi[0]); end
   endtask

   task automatic ramp_seq(input int target, input int a, input int b, input int c, input int d);
      int exp_d [4];
      logic exp_r [4];
      exp_d = '{a, b, c, d};
      exp_r = '{1'b1, 1'b1, 1'b1, 1'b0};
      wr_duty(3, target);
      wait_sync(100, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ramp_wait got=timeout want=sync"); end
      for (int p = 0; p < 4; p++) begin
         measure(10);
         total++;
         if (hi[3] != exp_d[p]) begin
            bad++; $display("FAIL ramp_duty step=%0d got=%0d want=%0d", p, hi[3], exp_d[p]);
         end
         total++;
         if (ramp_mid[3] !== exp_r[p]) begin
            bad++; $display("FAIL ramp_flag step=%0d got=%b want=%b", p, ramp_mid[3], exp_r[p]);
         end
      end
   endtask

   task automatic test_ramp();
      ramp_en = 1'b1;
      ramp_step = 4'd3;
      ramp_seq(10, 3, 6, 9, 10);
      ramp_seq(0, 7, 4, 1, 0);
      ramp_step = 4'd0;
      wr_duty(3, 2);
      wait_sync(100, ok);
      measure(10);
      total++;
      if (hi[3] != 1) begin bad++; $display("FAIL ramp_step0_a got=%0d want=1", hi[3]); end
      measure(10);
      total++;
      if (hi[3] != 2) begin bad++; $display("FAIL ramp_step0_b got=%0d want=2", hi[3]); end
      ramp_en = 1'b0;
   endtask

   task automatic test_out_of_range();
      int exp_hi [CH];
      exp_hi = '{7, 5, 0, 2, 10};
      wr_duty(4, 12);
      wr_duty(5, 4);
      wr_duty(7, 9);
      wait_sync(100, ok);
      measure(10);
      for (int c = 0; c < CH; c++) begin
         total++;
         if (hi[c] != exp_hi[c]) begin
            bad++; $display("FAIL oor_ch%0d got=%0d want=%0d", c, hi[c], exp_hi[c]);
         end
      end
      total++;
      if (ramp_mid !== '0) begin bad++; $display("FAIL oor_ramping got=%b want=0", ramp_mid); end
   endtask

   task automatic test_async_reset();
      int first;
      int highs;
      wait_sync(100, ok);
      total++;
      if (pwm_out[4] !== 1'b1 || sync !== 1'b1) begin
         bad++; $display("FAIL ar_pre got=%b/%b want=1/1", pwm_out[4], sync);
      end
      #1 rst = 1'b1;
      #1;
      total++;
      if (pwm_out !== '0) begin bad++; $display("FAIL ar_pwm got=%b want=0", pwm_out); end
      total++;
      if (sync !== 1'b0) begin bad++; $display("FAIL ar_sync got=%b want=0", sync); end
      total++;
      if (ramping !== '0) begin bad++; $display("FAIL ar_ramping got=%b want=0", ramping); end
      @(negedge clk);
      rst = 1'b0;
      first = 0;
      highs = 0;
      for (int k = 1; k <= 300 && first == 0; k++) begin
         @(negedge clk);
         highs += $countones(pwm_out);
         if (sync) first = k;
      end
      total++;
      if (first != 256) begin bad++; $display("FAIL ar_restart got=%0d want=256", first); end
      total++;
      if (highs != 0) begin bad++; $display("FAIL ar_duty got=%0d want=0", highs); end
   endtask

   initial begin
      rst = 1'b1;
      presc = 6'd0;
      per_wr = 1'b0; per_val = 8'd0;
      duty_wr = 1'b0; duty_ch = 3'd0; duty_val = 8'd0;
      ramp_en = 1'b0; ramp_step = 4'd0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_clamps();
      test_boundary_write();
      test_ramp();
      test_out_of_range();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
